line_buffer_ctrl: RTL and testbench

- Sequencer for the 3x3 line-buffer / window stage of the conv pipeline.
- Accepts a raster pixel stream for one frame and drives the line buffer's write enable, column address and row-rotate strobe.
- Emits a window-valid strobe with the window centre coordinates and a 9-bit zero-padding mask.
- Inserts the stall and drain cycles needed so every pixel, including right and bottom edges, gets exactly one centred 3x3 window.

---
 rtl/line_buffer_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_line_buffer_ctrl.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_ctrl.sv
// Sequencer for the 3x3 line-buffer window stage: drives line-buffer writes and
// emits one centred window (with zero-padding mask) per pixel of the frame.
module line_buffer_ctrl #(
   parameter int IMG_W    = 8,
   parameter int IMG_H    = 8,
   parameter int CNT_BITS = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                in_valid,
   output logic                in_ready,
   output logic                lb_wr_en,
   output logic [CNT_BITS-1:0] lb_addr,
   output logic                lb_shift,
   output logic                win_valid,
   output logic [CNT_BITS-1:0] win_row,
   output logic [CNT_BITS-1:0] win_col,
   output logic [8:0]          pad_mask,
   output logic                busy,
   output logic                frame_done
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FILL  = 3'd1,
      ST_RUN   = 3'd2,
      ST_EDGE  = 3'd3,
      ST_FLUSH = 3'd4
   } state_t;

   localparam logic [CNT_BITS-1:0] ZERO     = CNT_BITS'(0);
   localparam logic [CNT_BITS-1:0] ONE      = CNT_BITS'(1);
   localparam logic [CNT_BITS-1:0] TWO      = CNT_BITS'(2);
   localparam logic [CNT_BITS-1:0] LAST_COL = CNT_BITS'(IMG_W - 1);
   localparam logic [CNT_BITS-1:0] LAST_ROW = CNT_BITS'(IMG_H - 1);
   localparam logic [CNT_BITS-1:0] ROWS     = CNT_BITS'(IMG_H);

   // Taps of a window centred on (row, col) that fall outside the image.
   function automatic logic [8:0] calc_pad_mask(input logic [CNT_BITS-1:0] row,
                                                input logic [CNT_BITS-1:0] col);
      logic [8:0] m;
      m = 9'd0;
      if (row == ZERO) m = m | 9'h007;
      else             m = m;
      if (row == LAST_ROW) m = m | 9'h1C0;
      else                 m = m;
      if (col == ZERO) m = m | 9'h049;
      else             m = m;
      if (col == LAST_COL) m = m | 9'h124;
      else                 m = m;
      return m;
   endfunction

   state_t              state_r, state_nx_s;
   logic [CNT_BITS-1:0] ri_r, ci_r, fc_r;
   logic [CNT_BITS-1:0] ri_nx_s, ci_nx_s, fc_nx_s;
   logic                ready_s;
   logic                gen_s;
   logic [CNT_BITS-1:0] gen_row_s, gen_col_s;

   // Next-state, counter and window-generation logic.
   always_comb begin
      state_nx_s = state_r;
      ri_nx_s    = ri_r;
      ci_nx_s    = ci_r;
      fc_nx_s    = fc_r;
      ready_s    = 1'b0;
      gen_s      = 1'b0;
      gen_row_s  = ZERO;
      gen_col_s  = ZERO;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_nx_s = ST_FILL;
               ri_nx_s    = ZERO;
               ci_nx_s    = ZERO;
               fc_nx_s    = ZERO;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_FILL: begin
            ready_s = 1'b1;
            if (in_valid) begin
               if (ci_r == LAST_COL) begin
                  ci_nx_s    = ZERO;
                  ri_nx_s    = ri_r + ONE;
                  state_nx_s = ST_RUN;
               end else begin
                  ci_nx_s = ci_r + ONE;
               end
            end else begin
               ci_nx_s = ci_r;
            end
         end
         ST_RUN: begin
            ready_s = 1'b1;
            if (in_valid) begin
               // The window lags the input by one row and one column.
               if (ci_r != ZERO) begin
                  gen_s     = 1'b1;
                  gen_row_s = ri_r - ONE;
                  gen_col_s = ci_r - ONE;
               end else begin
                  gen_s = 1'b0;
               end
               if (ci_r == LAST_COL) begin
                  ci_nx_s    = ZERO;
                  ri_nx_s    = ri_r + ONE;
                  state_nx_s = ST_EDGE;
               end else begin
                  ci_nx_s = ci_r + ONE;
               end
            end else begin
               ci_nx_s = ci_r;
            end
         end
         ST_EDGE: begin
            // ri_r already points past the row just completed.
            gen_s     = 1'b1;
            gen_row_s = ri_r - TWO;
            gen_col_s = LAST_COL;
            if (ri_r < ROWS) begin
               state_nx_s = ST_RUN;
            end else begin
               state_nx_s = ST_FLUSH;
               fc_nx_s    = ZERO;
            end
         end
         ST_FLUSH: begin
            gen_s     = 1'b1;
            gen_row_s = LAST_ROW;
            gen_col_s = fc_r;
            if (fc_r == LAST_COL) begin
               state_nx_s = ST_IDLE;
               fc_nx_s    = ZERO;
               ri_nx_s    = ZERO;
               ci_nx_s    = ZERO;
            end else begin
               fc_nx_s = fc_r + ONE;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // Line-buffer handshake is combinational so writes land in the accept cycle.
   always_comb begin
      in_ready = ready_s;
      lb_wr_en = in_valid & ready_s;
      lb_addr  = ci_r;
      lb_shift = in_valid & ready_s & (ci_r == LAST_COL);
   end

   // State and counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
         ri_r    <= ZERO;
         ci_r    <= ZERO;
         fc_r    <= ZERO;
      end else begin
         state_r <= state_nx_s;
         ri_r    <= ri_nx_s;
         ci_r    <= ci_nx_s;
         fc_r    <= fc_nx_s;
      end
   end

   // Registered window outputs; coordinates and mask hold between windows.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         win_valid  <= 1'b0;
         win_row    <= ZERO;
         win_col    <= ZERO;
         pad_mask   <= 9'd0;
         frame_done <= 1'b0;
         busy       <= 1'b0;
      end else begin
         win_valid  <= gen_s;
         frame_done <= gen_s & (gen_row_s == LAST_ROW) & (gen_col_s == LAST_COL);
         busy       <= (state_nx_s != ST_IDLE);
         if (gen_s) begin
            win_row  <= gen_row_s;
            win_col  <= gen_col_s;
            pad_mask <= calc_pad_mask(gen_row_s, gen_col_s);
         end else begin
            win_row  <= win_row;
            win_col  <= win_col;
            pad_mask <= pad_mask;
         end
      end
   end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Scoreboard bench for line_buffer_ctrl: a 4x4 instance for most scenarios and a
// 2x3 instance for the narrow-image case.
module tb_line_buffer_ctrl;

   localparam int W1 = 4;
   localparam int H1 = 4;
   localparam int W2 = 2;
   localparam int H2 = 3;
   localparam int CB = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start1 = 1'b0, in_valid1 = 1'b0;
   logic start2 = 1'b0, in_valid2 = 1'b0;

   logic          in_ready1, lb_wr_en1, lb_shift1, win_valid1, busy1, frame_done1;
   logic [CB-1:0] lb_addr1, win_row1, win_col1;
   logic [8:0]    pad_mask1;
   logic          in_ready2, lb_wr_en2, lb_shift2, win_valid2, busy2, frame_done2;
   logic [CB-1:0] lb_addr2, win_row2, win_col2;
   logic [8:0]    pad_mask2;

   int errors = 0;
   int checks = 0;

   logic [24:0] q1[$];
   logic [24:0] q2[$];
   logic [24:0] e1, e2;
   logic        exp_fd1, exp_fd2;
   int          win_count1 = 0, win_count2 = 0;
   logic [8:0]  mask_seen1[16];
   logic [8:0]  mask_seen2[6];
   int          done_row2 = -1, done_col2 = -1;
   int          idx1, idx2;

   int acc_cnt, shift_cnt, bad_shift, bad_wr, addr_err;
   bit rdy_hist[256];

   line_buffer_ctrl #(.IMG_W(W1), .IMG_H(H1), .CNT_BITS(CB)) dut (
      .clk(clk), .reset(reset), .start(start1), .in_valid(in_valid1),
      .in_ready(in_ready1), .lb_wr_en(lb_wr_en1), .lb_addr(lb_addr1), .lb_shift(lb_shift1),
      .win_valid(win_valid1), .win_row(win_row1), .win_col(win_col1), .pad_mask(pad_mask1),
      .busy(busy1), .frame_done(frame_done1)
   );

   line_buffer_ctrl #(.IMG_W(W2), .IMG_H(H2), .CNT_BITS(CB)) dut2 (
      .clk(clk), .reset(reset), .start(start2), .in_valid(in_valid2),
      .in_ready(in_ready2), .lb_wr_en(lb_wr_en2), .lb_addr(lb_addr2), .lb_shift(lb_shift2),
      .win_valid(win_valid2), .win_row(win_row2), .win_col(win_col2), .pad_mask(pad_mask2),
      .busy(busy2), .frame_done(frame_done2)
   );

   always #5 clk = ~clk;

   // Mask from geometry: a tap is padded when its pixel lies outside the image.
   function automatic logic [8:0] exp_mask(int r, int c, int w, int h);
      logic [8:0] m;
      int rr, cc;
      m = 9'd0;
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            rr = r + i - 1;
            cc = c + j - 1;
            if (rr < 0 || rr >= h || cc < 0 || cc >= w) m[3*i+j] = 1'b1;
         end
      end
      return m;
   endfunction

   function automatic logic [24:0] pack_win(int r, int c, int w, int h);
      return {8'(r), 8'(c), exp_mask(r, c, w, h)};
   endfunction

   function automatic bit exp_ready(int k);
      if (k < W1) return 1'b1;
      if (k < W1 + (H1 - 1) * (W1 + 1)) return ((k - W1) % (W1 + 1)) < W1;
      return 1'b0;
   endfunction

   // Scoreboard monitor for the 4x4 instance.
   always @(negedge clk) begin
      if (reset !== 1'b1) begin
         if (win_valid1 === 1'b1) begin
            win_count1++;
            checks++;
            if (q1.size() == 0) begin
               errors++;
               $display("FAIL sb1_unexpected: got window (%0d,%0d), required none", win_row1, win_col1);
            end else begin
               e1 = q1.pop_front();
               if ({win_row1, win_col1, pad_mask1} !== e1) begin
                  errors++;
                  $display("FAIL sb1_window: got (%0d,%0d) mask %h, required (%0d,%0d) mask %h",
                           win_row1, win_col1, pad_mask1, e1[24:17], e1[16:9], e1[8:0]);
               end
               exp_fd1 = (e1[24:17] == 8'(H1 - 1)) && (e1[16:9] == 8'(W1 - 1));
               checks++;
               if (frame_done1 !== exp_fd1) begin
                  errors++;
                  $display("FAIL sb1_frame_done: got %b, required %b", frame_done1, exp_fd1);
               end
               idx1 = int'(e1[24:17]) * W1 + int'(e1[16:9]);
               if (idx1 < 16) mask_seen1[idx1] = pad_mask1;
            end
         end else begin
            checks++;
            if (frame_done1 !== 1'b0) begin
               errors++;
               $display("FAIL sb1_done_idle: got %b, required 0", frame_done1);
            end
         end
      end
   end

   // Scoreboard monitor for the 2x3 instance.
   always @(negedge clk) begin
      if (reset !== 1'b1 && win_valid2 === 1'b1) begin
         win_count2++;
         checks++;
         if (q2.size() == 0) begin
            errors++;
            $display("FAIL sb2_unexpected: got window (%0d,%0d), required none", win_row2, win_col2);
         end else begin
            e2 = q2.pop_front();
            if ({win_row2, win_col2, pad_mask2} !== e2) begin
               errors++;
               $display("FAIL sb2_window: got (%0d,%0d) mask %h, required (%0d,%0d) mask %h",
                        win_row2, win_col2, pad_mask2, e2[24:17], e2[16:9], e2[8:0]);
            end
            exp_fd2 = (e2[24:17] == 8'(H2 - 1)) && (e2[16:9] == 8'(W2 - 1));
            checks++;
            if (frame_done2 !== exp_fd2) begin
               errors++;
               $display("FAIL sb2_frame_done: got %b, required %b", frame_done2, exp_fd2);
            end
            idx2 = int'(e2[24:17]) * W2 + int'(e2[16:9]);
            if (idx2 < 6) mask_seen2[idx2] = pad_mask2;
         end
         if (frame_done2 === 1'b1) begin
            done_row2 = int'(win_row2);
            done_col2 = int'(win_col2);
         end
      end
   end

   task automatic push_frame1();
      for (int r = 0; r < H1; r++)
         for (int c = 0; c < W1; c++)
            q1.push_back(pack_win(r, c, W1, H1));
   endtask

   // Runs one 4x4 frame from IDLE, returning the cycle (from FILL entry) where busy fell.
   task automatic drive_frame(input bit tog, input bit noise, output int end_cyc);
      int cyc;
      bit fin;
      push_frame1();
      win_count1 = 0;
      acc_cnt = 0; shift_cnt = 0; bad_shift = 0; bad_wr = 0; addr_err = 0;
      for (int k = 0; k < 256; k++) rdy_hist[k] = 1'b0;
      start1 = 1'b1;
      in_valid1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      cyc = 0;
      fin = 1'b0;
      end_cyc = -1;
      while (!fin && cyc < 250) begin
         in_valid1 = tog ? ((cyc % 2) == 0) : 1'b1;
         start1 = noise && ((cyc % 2) == 1) && (cyc < 21);
         @(negedge clk);
         rdy_hist[cyc] = in_ready1;
         if (lb_wr_en1 === 1'b1) begin
            if (in_valid1 !== 1'b1) bad_wr++;
            if (lb_addr1 !== 8'(acc_cnt % W1)) addr_err++;
            acc_cnt++;
         end
         if (lb_shift1 === 1'b1) begin
            shift_cnt++;
            if (lb_wr_en1 !== 1'b1 || lb_addr1 !== 8'(W1 - 1)) bad_shift++;
         end
         if (busy1 === 1'b0) begin
            fin = 1'b1;
            end_cyc = cyc;
         end else begin
            @(posedge clk); #1;
            cyc++;
         end
      end
      #1;
      start1 = 1'b0;
      in_valid1 = 1'b0;
      checks++;
      if (!fin) begin
         errors++;
         $display("FAIL frame_timeout: busy still %b after %0d cycles, required 0", busy1, cyc);
      end
      checks++;
      if (win_count1 != W1 * H1) begin
         errors++;
         $display("FAIL win_count: got %0d, required %0d", win_count1, W1 * H1);
      end
      checks++;
      if (q1.size() != 0) begin
         errors++;
         $display("FAIL sb1_leftover: got %0d pending, required 0", q1.size());
      end
      q1.delete();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({in_ready1, lb_wr_en1, lb_shift1, win_valid1, busy1, frame_done1} !== 6'd0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b, required 000000",
                  {in_ready1, lb_wr_en1, lb_shift1, win_valid1, busy1, frame_done1});
      end
      checks++;
      if ({lb_addr1, win_row1, win_col1, pad_mask1} !== 33'd0) begin
         errors++;
         $display("FAIL reset_data: got addr %0d row %0d col %0d mask %h, required all 0",
                  lb_addr1, win_row1, win_col1, pad_mask1);
      end
      checks++;
      if ({in_ready2, win_valid2, busy2, frame_done2, pad_mask2} !== 13'd0) begin
         errors++;
         $display("FAIL reset_dut2: got %b, required 0", {in_ready2, win_valid2, busy2, frame_done2, pad_mask2});
      end
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_full_frame();
      int endc;
      drive_frame(1'b0, 1'b0, endc);
      checks++;
      if (endc != 23) begin
         errors++;
         $display("FAIL busy_low_cycle: got %0d, required 23", endc);
      end
      for (int k = 0; k < 24; k++) begin
         checks++;
         if (rdy_hist[k] !== exp_ready(k)) begin
            errors++;
            $display("FAIL in_ready_cyc%0d: got %b, required %b", k, rdy_hist[k], exp_ready(k));
         end
      end
      checks++;
      if (acc_cnt != 16 || shift_cnt != 4) begin
         errors++;
         $display("FAIL full_accepts: got %0d accepts %0d shifts, required 16 and 4", acc_cnt, shift_cnt);
      end
   endtask

   task automatic test_pad_mask();
      int         idx_t[7] = '{0, 3, 12, 15, 5, 1, 11};
      logic [8:0] msk_t[7] = '{9'h04F, 9'h127, 9'h1C9, 9'h1E4, 9'h000, 9'h007, 9'h124};
      for (int k = 0; k < 7; k++) begin
         checks++;
         if (mask_seen1[idx_t[k]] !== msk_t[k]) begin
            errors++;
            $display("FAIL pad_mask_(%0d,%0d): got %h, required %h",
                     idx_t[k] / W1, idx_t[k] % W1, mask_seen1[idx_t[k]], msk_t[k]);
         end
      end
   endtask

   task automatic test_toggle();
      int endc;
      drive_frame(1'b1, 1'b0, endc);
      checks++;
      if (acc_cnt != 16) begin
         errors++;
         $display("FAIL toggle_accepts: got %0d, required 16", acc_cnt);
      end
      checks++;
      if (shift_cnt != 4 || bad_shift != 0) begin
         errors++;
         $display("FAIL toggle_shift: got %0d shifts %0d misplaced, required 4 and 0", shift_cnt, bad_shift);
      end
      checks++;
      if (bad_wr != 0 || addr_err != 0) begin
         errors++;
         $display("FAIL toggle_wr: got %0d stray writes %0d bad addrs, required 0 and 0", bad_wr, addr_err);
      end
   endtask

   task automatic test_back_to_back();
      int endc;
      drive_frame(1'b0, 1'b1, endc);
      checks++;
      if (endc != 23) begin
         errors++;
         $display("FAIL noisy_start_len: got %0d, required 23", endc);
      end
      drive_frame(1'b0, 1'b0, endc);
      checks++;
      if (endc != 23) begin
         errors++;
         $display("FAIL second_frame_len: got %0d, required 23", endc);
      end
   endtask

   task automatic test_reset_mid();
      int acc;
      int cyc;
      int endc;
      push_frame1();
      start1 = 1'b1;
      in_valid1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      acc = 0;
      cyc = 0;
      while (acc < 7 && cyc < 50) begin
         @(negedge clk);
         if (lb_wr_en1 === 1'b1) acc++;
         cyc++;
      end
      checks++;
      if (acc != 7) begin
         errors++;
         $display("FAIL mid_accepts: got %0d, required 7", acc);
      end
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({in_ready1, lb_wr_en1, lb_shift1, win_valid1, busy1, frame_done1} !== 6'd0) begin
         errors++;
         $display("FAIL mid_reset_ctrl: got %b, required 000000",
                  {in_ready1, lb_wr_en1, lb_shift1, win_valid1, busy1, frame_done1});
      end
      checks++;
      if ({lb_addr1, win_row1, win_col1, pad_mask1} !== 33'd0) begin
         errors++;
         $display("FAIL mid_reset_data: got addr %0d row %0d col %0d mask %h, required all 0",
                  lb_addr1, win_row1, win_col1, pad_mask1);
      end
      q1.delete();
      in_valid1 = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      drive_frame(1'b0, 1'b0, endc);
      checks++;
      if (endc != 23) begin
         errors++;
         $display("FAIL post_reset_len: got %0d, required 23", endc);
      end
   endtask

   task automatic test_small_image();
      int cyc;
      bit fin;
      for (int r = 0; r < H2; r++)
         for (int c = 0; c < W2; c++)
            q2.push_back(pack_win(r, c, W2, H2));
      win_count2 = 0;
      start2 = 1'b1;
      in_valid2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      cyc = 0;
      fin = 1'b0;
      while (!fin && cyc < 100) begin
         @(negedge clk);
         if (busy2 === 1'b0) fin = 1'b1;
         else begin
            @(posedge clk); #1;
            cyc++;
         end
      end
      #1;
      in_valid2 = 1'b0;
      checks++;
      if (!fin || cyc != 10) begin
         errors++;
         $display("FAIL small_len: got busy low at %0d (done=%b), required 10", cyc, fin);
      end
      checks++;
      if (win_count2 != 6 || q2.size() != 0) begin
         errors++;
         $display("FAIL small_count: got %0d windows %0d pending, required 6 and 0", win_count2, q2.size());
      end
      checks++;
      if (mask_seen2[3] !== 9'h124 || mask_seen2[0] !== 9'h04F) begin
         errors++;
         $display("FAIL small_masks: got (1,1)=%h (0,0)=%h, required 124 and 04f", mask_seen2[3], mask_seen2[0]);
      end
      checks++;
      if (done_row2 != 2 || done_col2 != 1) begin
         errors++;
         $display("FAIL small_done_pos: got (%0d,%0d), required (2,1)", done_row2, done_col2);
      end
   endtask

   initial begin
      for (int k = 0; k < 16; k++) mask_seen1[k] = 9'h1FF;
      for (int k = 0; k < 6; k++) mask_seen2[k] = 9'h1FF;
      test_reset();
      test_full_frame();
      test_pad_mask();
      for (int k = 0; k < 16; k++) mask_seen1[k] = 9'h1FF;
      test_toggle();
      test_pad_mask();
      test_back_to_back();
      test_reset_mid();
      test_small_image();
      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
